// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states
// and the ALUOp / ALUSrcB / PCSource select values.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that hold a memory access open until MemReady.
  function automatic logic is_wait_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/pc_enable_logic.sv
// PC load enable: merges the unconditional write with the branch decision.
// Optional macro BNE_EN adds the branch-not-equal term.
module pc_enable_logic (
  input  logic pcwrite,
  input  logic branch,
`ifdef BNE_EN
  input  logic branch_ne,
`endif
  input  logic zero,
  output logic pcen
);

`ifdef BNE_EN
  assign pcen = pcwrite | (branch & zero) | (branch_ne & ~zero);
`else
  assign pcen = pcwrite | (branch & zero);
`endif

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath with a memory ready
// handshake and optional wait timeout. Optional macro BNE_EN adds bne.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCEn,
  output logic       PCWrite,
  output logic       Branch,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       InstrDone,
  output logic       Illegal,
`ifdef BNE_EN
  output logic       BranchNe,
`endif
  output logic       MemErr
);

  localparam bit              TO_EN   = (MEM_TIMEOUT > 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t          state, state_next;
  logic [TO_W-1:0] wait_cnt, wait_cnt_next;
  logic            waiting, timeout;

  // A waiting cycle is a memory state whose access has not completed yet.
  assign waiting       = is_wait_state(state) && !MemReady;
  assign timeout       = TO_EN && waiting && (wait_cnt == TO_LAST);
  assign wait_cnt_next = (waiting && !timeout) ? wait_cnt + TO_W'(1) : '0;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      MemErr   <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (timeout) MemErr <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    state_next = state;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_B;
    ALUOp      = ALUOP_ADD;
    PCSource   = PCSRC_ALU;
    InstrDone  = 1'b0;
    Illegal    = 1'b0;
`ifdef BNE_EN
    BranchNe   = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = MemReady;
        PCWrite = MemReady;
        if (MemReady) state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMMSH;
        case (Op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JEX;
`ifdef BNE_EN
          OP_BNE:       state_next = S_BNEEX;
`endif
          default: begin
            Illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        state_next = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (MemReady) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        InstrDone  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        IorD      = 1'b1;
        MemWrite  = 1'b1;
        InstrDone = MemReady;
        if (MemReady) state_next = S_FETCH;
      end
      S_RTYPEEX: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALUOP_FUNCT;
        state_next = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        InstrDone  = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQEX: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALUOP_SUB;
        PCSource   = PCSRC_ALUOUT;
        Branch     = 1'b1;
        InstrDone  = 1'b1;
        state_next = S_FETCH;
      end
`ifdef BNE_EN
      S_BNEEX: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALUOP_SUB;
        PCSource   = PCSRC_ALUOUT;
        BranchNe   = 1'b1;
        InstrDone  = 1'b1;
        state_next = S_FETCH;
      end
`endif
      S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        InstrDone  = 1'b1;
        state_next = S_FETCH;
      end
      S_JEX: begin
        PCSource   = PCSRC_JUMP;
        PCWrite    = 1'b1;
        InstrDone  = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase

    // A timed-out access abandons the instruction; FETCH retries the same PC.
    if (timeout) begin
      state_next = S_FETCH;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      InstrDone  = 1'b0;
    end
  end

  pc_enable_logic u_pc_enable (
    .pcwrite   (PCWrite),
    .branch    (Branch),
`ifdef BNE_EN
    .branch_ne (BranchNe),
`endif
    .zero      (Zero),
    .pcen      (PCEn)
  );

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS datapath. Sequences fetch/decode/execute/memory/writeback and drives every datapath select and enable.
- Merges the conditional branch decision into a single PC enable (PCEn = PCWrite | (Branch & Zero)).
- Adds a ready handshake to instruction/data memory, with an optional wait timeout.

Parameters:
- MEM_TIMEOUT, 0, max cycles to wait for MemReady per access; 0 = wait forever.
- TO_W, 8, width of the wait counter; requires MEM_TIMEOUT < 2**TO_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- Op  in  6  IR[31:26], stable outside FETCH
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes the current access this cycle
- PCEn  out  1  PC register load enable
- PCWrite  out  1  unconditional PC write
- Branch  out  1  conditional PC write (beq)
- IorD  out  1  memory address: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  IR load enable
- RegDst  out  1  write reg: 0=rt, 1=rd
- MemtoReg  out  1  write data: 0=ALUOut, 1=MDR
- RegWrite  out  1  regfile write enable
- ALUSrcA  out  1  0=PC, 1=A
- ALUSrcB  out  2  00=B, 01=4, 10=SignImm, 11=SignImm<<2
- ALUOp  out  2  00=add, 01=sub, 10=funct
- PCSource  out  2  00=ALUResult, 01=ALUOut, 10=jump target
- InstrDone  out  1  one-cycle pulse in the last state of each instruction
- Illegal  out  1  one-cycle pulse when DECODE sees an unknown Op
- MemErr  out  1  sticky; set on memory timeout

Behaviour:
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
- 4-bit state register. Outputs are decoded from the state; only the MemReady gating noted below is combinational. Every output not listed for a state is 0.
- Reset: while rst is high at a clock edge, state <- FETCH, counter <- 0, MemErr <- 0. After reset, outputs take FETCH values.
- FETCH: MemRead=1, ALUSrcB=01, IRWrite=PCWrite=MemReady. Go to DECODE on MemReady, otherwise stay.
- DECODE: ALUSrcB=11. Next state by Op: lw/sw -> MEMADR, R -> RTYPEEX, beq -> BEQEX, addi -> ADDIEX, j -> JEX, anything else -> FETCH with Illegal=1.
- MEMADR: ALUSrcA=1, ALUSrcB=10. Go to MEMRD if Op=lw, else MEMWR.
- MEMRD: IorD=1, MemRead=1. Go to MEMWB on MemReady, else hold.
- MEMWB: MemtoReg=1, RegWrite=1, InstrDone=1. Go to FETCH.
- MEMWR: IorD=1, MemWrite=1, InstrDone=MemReady. Go to FETCH on MemReady, else hold with MemWrite still asserted.
- RTYPEEX: ALUSrcA=1, ALUOp=10. Go to RTYPEWB.
- RTYPEWB: RegDst=1, RegWrite=1, InstrDone=1. Go to FETCH.
- BEQEX: ALUSrcA=1, ALUOp=01, PCSource=01, Branch=1, InstrDone=1. Go to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10. Go to ADDIWB.
- ADDIWB: RegWrite=1, InstrDone=1. Go to FETCH.
- JEX: PCSource=10, PCWrite=1, InstrDone=1. Go to FETCH.
- PCEn = PCWrite | (Branch & Zero), combinational.
- Cycle counts with zero wait: lw=5, sw=4, R=4, addi=4, beq=3, j=3.
- Wait counter:
  - Clears on entry to FETCH/MEMRD/MEMWR and whenever MemReady=1.
  - Increments each waiting cycle.
  - If MEM_TIMEOUT>0 and counter==MEM_TIMEOUT-1 with MemReady=0: set MemErr, go to FETCH, suppress IRWrite, PCWrite and InstrDone.
  - A timed-out FETCH retries the same PC.
- Unused state encodings -> FETCH.
- rst asserted mid-instruction aborts it. No partial RegWrite/MemWrite is issued after that edge.

Optional Feature:
- BNE_EN defined:
  - Adds bne (000101) -> BNEEX state: same outputs as BEQEX, but Branch=0 and a new output BranchNe=1.
  - PCEn = PCWrite | (Branch & Zero) | (BranchNe & ~Zero).
  - BranchNe port exists and is 0 in all other states.
- BNE_EN undefined: no BranchNe port, and 000101 decodes as Illegal.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_BNE)
  - state encoding constants
  - ALUOp, ALUSrcB and PCSource encodings
- Sub-module: pc_enable_logic, the combinational PCEn merge, so the branch decision is kept separate from the FSM.

Test Plan:
- rst=1 for 2 cycles, then Op=100011 with MemReady always 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 and MemtoReg=1 in cycle 5; InstrDone pulses once.
- beq with Zero=1 -> PCEn=1 in BEQEX with PCSource=01. Repeat with Zero=0 -> PCEn=0.
- sw with MemReady low for 3 cycles in MEMWR -> MemWrite held 4 cycles; exits on the ready cycle; InstrDone only then.
- MEM_TIMEOUT=4, MemReady stuck 0 in FETCH -> MemErr rises after 4 cycles; state returns to FETCH; IRWrite is never 1.
- Op=111111 -> Illegal pulses in DECODE, then FETCH. With BNE_EN defined, Op=000101 and Zero=0 -> PCEn=1 and BranchNe=1.
- rst asserted in RTYPEEX -> next cycle is FETCH, and no RegWrite pulse occurs.
